// File: rtl/collision_scanner.sv
// Bounding-box collision scan of a snapshotted enemy list against the player,
// one enemy per clock, plus four player tile probes for the wall lookup.
//
// state | meaning
// IDLE  | waiting for start; outputs hold the last committed results
// SCAN  | evaluating enemy[idx] each cycle, accumulating hits
// DONE  | committing accumulator and probes, pulsing done
module collision_scanner #(
  parameter  int NUM_ENEMIES  = 4,
  parameter  int COORD_W      = 10,
  parameter  int SPRITE_SIZE  = 16,
  parameter  int PROBE_MARGIN = 2,
  parameter  int ORIGIN_X     = 144,
  parameter  int ORIGIN_Y     = 31,
  parameter  int TILE_SHIFT   = 5,
  parameter  int TILE_W       = 6,
  localparam int IDX_W        = (NUM_ENEMIES > 1) ? $clog2(NUM_ENEMIES) : 1
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            start,
  input  logic [2*COORD_W-1:0]            player_pos,
  input  logic [NUM_ENEMIES*2*COORD_W-1:0] enemy_pos,
  input  logic [NUM_ENEMIES-1:0]          enemy_active,
  output logic                            busy,
  output logic                            done,
  output logic [NUM_ENEMIES-1:0]          hit_mask,
  output logic                            any_hit,
  output logic [IDX_W-1:0]                first_hit_idx,
  output logic [4*TILE_W-1:0]             probe_x,
  output logic [4*TILE_W-1:0]             probe_y,
  output logic [3:0]                      probe_oob
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_SCAN = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam int DW = COORD_W + 1;

  logic [1:0]                       state;
  logic [IDX_W-1:0]                 idx;
  logic [COORD_W-1:0]               snap_px;
  logic [COORD_W-1:0]               snap_py;
  logic [NUM_ENEMIES*2*COORD_W-1:0] snap_enemy;
  logic [NUM_ENEMIES-1:0]           snap_active;
  logic [NUM_ENEMIES-1:0]           hit_acc;

  logic [2*COORD_W-1:0] cur_enemy;
  logic signed [DW-1:0] dx;
  logic signed [DW-1:0] dy;
  logic [DW-1:0]        adx;
  logic [DW-1:0]        ady;
  logic                 cur_hit;

  // Zero-extended operands keep the difference exact: no wrap at the coordinate edge.
  always_comb begin
    cur_enemy = snap_enemy[int'(idx)*2*COORD_W +: 2*COORD_W];
    dx = $signed({1'b0, cur_enemy[2*COORD_W-1:COORD_W]}) - $signed({1'b0, snap_px});
    dy = $signed({1'b0, cur_enemy[COORD_W-1:0]}) - $signed({1'b0, snap_py});
    adx = dx[DW-1] ? $unsigned(-dx) : $unsigned(dx);
    ady = dy[DW-1] ? $unsigned(-dy) : $unsigned(dy);
    cur_hit = snap_active[idx] && (int'(adx) <= SPRITE_SIZE) && (int'(ady) <= SPRITE_SIZE);
  end

  logic signed [31:0] base_x;
  logic signed [31:0] base_y;
  logic signed [31:0] off_x [4];
  logic signed [31:0] off_y [4];
  logic [4*TILE_W-1:0] probe_x_nxt;
  logic [4*TILE_W-1:0] probe_y_nxt;
  logic [3:0]          probe_oob_nxt;

  always_comb begin
    base_x = signed'(32'(snap_px)) - ORIGIN_X;
    base_y = signed'(32'(snap_py)) - ORIGIN_Y;
    off_x[0] = base_x;
    off_y[0] = base_y - PROBE_MARGIN;
    off_x[1] = base_x + SPRITE_SIZE + PROBE_MARGIN;
    off_y[1] = base_y;
    off_x[2] = base_x;
    off_y[2] = base_y + SPRITE_SIZE + PROBE_MARGIN;
    off_x[3] = base_x - PROBE_MARGIN;
    off_y[3] = base_y;
    probe_x_nxt   = '0;
    probe_y_nxt   = '0;
    probe_oob_nxt = '0;
    for (int k = 0; k < 4; k++) begin
      probe_oob_nxt[k] = off_x[k][31] | off_y[k][31];
      probe_x_nxt[k*TILE_W +: TILE_W] = off_x[k][31] ? '0 : TILE_W'(off_x[k] >>> TILE_SHIFT);
      probe_y_nxt[k*TILE_W +: TILE_W] = off_y[k][31] ? '0 : TILE_W'(off_y[k] >>> TILE_SHIFT);
    end
  end

  logic [IDX_W-1:0] first_idx_nxt;

  always_comb begin
    first_idx_nxt = '0;
    for (int i = NUM_ENEMIES - 1; i >= 0; i--) begin
      if (hit_acc[i]) first_idx_nxt = IDX_W'(i);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= ST_IDLE;
      idx           <= '0;
      snap_px       <= '0;
      snap_py       <= '0;
      snap_enemy    <= '0;
      snap_active   <= '0;
      hit_acc       <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
      hit_mask      <= '0;
      any_hit       <= 1'b0;
      first_hit_idx <= '0;
      probe_x       <= '0;
      probe_y       <= '0;
      probe_oob     <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          busy <= start;
          if (start) begin
            snap_px     <= player_pos[2*COORD_W-1:COORD_W];
            snap_py     <= player_pos[COORD_W-1:0];
            snap_enemy  <= enemy_pos;
            snap_active <= enemy_active;
            hit_acc     <= '0;
            idx         <= '0;
            state       <= ST_SCAN;
          end
        end
        ST_SCAN: begin
          hit_acc[idx] <= cur_hit;
          if (idx == IDX_W'(NUM_ENEMIES - 1)) begin
            state <= ST_DONE;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        ST_DONE: begin
          // busy stays high through the done cycle and drops on the next IDLE edge.
          hit_mask      <= hit_acc;
          any_hit       <= |hit_acc;
          first_hit_idx <= first_idx_nxt;
          probe_x       <= probe_x_nxt;
          probe_y       <= probe_y_nxt;
          probe_oob     <= probe_oob_nxt;
          done          <= 1'b1;
          state         <= ST_IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_collision_scanner.sv
// Directed bench for collision_scanner: hit boundaries, probes, latency,
// ignored starts, continuous start and mid-scan reset.
module tb_collision_scanner;
  localparam int N  = 4;
  localparam int CW = 10;
  localparam int TW = 6;
  localparam int IW = 2;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              start = 1'b0;
  logic [2*CW-1:0]   player_pos = '0;
  logic [N*2*CW-1:0] enemy_pos = '0;
  logic [N-1:0]      enemy_active = '0;
  logic              busy;
  logic              done;
  logic [N-1:0]      hit_mask;
  logic              any_hit;
  logic [IW-1:0]     first_hit_idx;
  logic [4*TW-1:0]   probe_x;
  logic [4*TW-1:0]   probe_y;
  logic [3:0]        probe_oob;

  collision_scanner dut (
    .clk(clk), .rst(rst), .start(start),
    .player_pos(player_pos), .enemy_pos(enemy_pos), .enemy_active(enemy_active),
    .busy(busy), .done(done), .hit_mask(hit_mask), .any_hit(any_hit),
    .first_hit_idx(first_hit_idx), .probe_x(probe_x), .probe_y(probe_y),
    .probe_oob(probe_oob)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic logic [2*CW-1:0] xy(input int x, input int y);
    return {CW'(x), CW'(y)};
  endfunction

  function automatic logic [4*TW-1:0] pack4(input int a0, input int a1, input int a2, input int a3);
    return {TW'(a3), TW'(a2), TW'(a1), TW'(a0)};
  endfunction

  logic [2*CW-1:0] far;

  // Start at edge T, scramble inputs afterwards, return edges until done is seen.
  task automatic run_scan(input logic [2*CW-1:0] p, input logic [N*2*CW-1:0] e,
                          input logic [N-1:0] act, output int lat);
    @(negedge clk);
    player_pos = p; enemy_pos = e; enemy_active = act; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    player_pos = xy(700, 700);
    enemy_pos = {N{xy(200, 100)}};
    enemy_active = '0;
    lat = -1;
    for (int k = 1; k <= 20 && lat < 0; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (done) lat = k;
    end
  endtask

  task automatic scan_check(input string tag, input logic [2*CW-1:0] p,
                            input logic [N*2*CW-1:0] e, input logic [N-1:0] act,
                            input logic [N-1:0] exp_mask, input int exp_first);
    int lat;
    run_scan(p, e, act, lat);
    check_val({tag, "_lat"}, 64'(lat), 64'(5));
    check_val({tag, "_mask"}, 64'(hit_mask), 64'(exp_mask));
    check_val({tag, "_any"}, 64'(any_hit), 64'(exp_mask != '0));
    check_val({tag, "_first"}, 64'(first_hit_idx), 64'(exp_first));
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    int n_done;
    int first_lat;
    int t_first;
    int t_second;
    far = xy(600, 400);

    repeat (3) @(posedge clk);
    @(negedge clk);
    check_val("rst_ctrl", 64'({busy, done, any_hit, hit_mask, first_hit_idx, probe_oob}), 64'(0));
    check_val("rst_probe", 64'({probe_x, probe_y}), 64'(0));
    rst = 1'b0;

    scan_check("single", xy(200, 100), {far, far, far, xy(210, 110)}, 4'b1111, 4'b0001, 0);
    check_val("busy_at_done", 64'(busy), 64'(1));
    check_val("probe_x", 64'(probe_x), 64'(pack4(1, 2, 1, 1)));
    check_val("probe_y", 64'(probe_y), 64'(pack4(2, 2, 2, 2)));
    check_val("probe_oob", 64'(probe_oob), 64'(4'b0000));
    @(posedge clk);
    @(negedge clk);
    check_val("busy_drop", 64'({busy, done}), 64'(0));
    check_val("hold_mask", 64'(hit_mask), 64'(4'b0001));

    scan_check("bound", xy(200, 100), {xy(184, 84), xy(217, 100), xy(216, 116), far},
               4'b1111, 4'b1010, 1);
    scan_check("inactive", xy(200, 100), {far, far, far, xy(200, 100)}, 4'b1110, 4'b0000, 0);

    scan_check("origin", xy(145, 31), {far, far, far, far}, 4'b1111, 4'b0000, 0);
    check_val("org_px", 64'(probe_x), 64'(0));
    check_val("org_py", 64'(probe_y), 64'(0));
    check_val("org_oob", 64'(probe_oob), 64'(4'b1001));

    scan_check("edge_hit", xy(0, 0), {far, far, far, xy(5, 5)}, 4'b1111, 4'b0001, 0);
    check_val("edge_oob", 64'(probe_oob), 64'(4'b1111));
    scan_check("edge_nowrap", xy(0, 0), {far, far, far, xy(1020, 0)}, 4'b1111, 4'b0000, 0);

    // Extra start pulse during busy must be dropped.
    @(negedge clk);
    player_pos = xy(200, 100); enemy_pos = {far, far, far, xy(210, 110)};
    enemy_active = 4'b1111; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    n_done = 0; first_lat = -1;
    for (int k = 1; k <= 15; k++) begin
      @(posedge clk);
      #1 start = (k == 1);
      @(negedge clk);
      if (done) begin
        n_done++;
        if (first_lat < 0) first_lat = k;
      end
    end
    start = 1'b0;
    check_val("busy_start_dones", 64'(n_done), 64'(1));
    check_val("busy_start_lat", 64'(first_lat), 64'(5));
    check_val("busy_start_mask", 64'(hit_mask), 64'(4'b0001));

    // Continuous start: one scan every NUM_ENEMIES+2 cycles.
    @(negedge clk);
    player_pos = xy(200, 100);
    enemy_pos = {xy(184, 84), xy(217, 100), xy(216, 116), far};
    start = 1'b1;
    t_first = -1; t_second = -1;
    for (int k = 1; k <= 30 && t_second < 0; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (done) begin
        if (t_first < 0) t_first = k;
        else t_second = k;
      end
    end
    start = 1'b0;
    check_val("cont_period", 64'(t_second - t_first), 64'(6));
    check_val("cont_mask", 64'(hit_mask), 64'(4'b1010));
    repeat (8) @(posedge clk);

    // Mid-scan reset: outputs clear at once and no done follows.
    @(negedge clk);
    player_pos = xy(200, 100); enemy_pos = {far, far, far, xy(210, 110)};
    enemy_active = 4'b1111; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    check_val("midrst_ctrl", 64'({busy, done, any_hit, hit_mask, first_hit_idx, probe_oob}), 64'(0));
    check_val("midrst_probe", 64'({probe_x, probe_y}), 64'(0));
    @(negedge clk);
    rst = 1'b0;
    n_done = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (done) n_done++;
    end
    check_val("midrst_nodone", 64'(n_done), 64'(0));
    scan_check("after_rst", xy(200, 100), {xy(184, 84), xy(217, 100), xy(216, 116), far},
               4'b1111, 4'b1010, 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
